// File: rtl/text_ram_scheduler.sv
// text_ram_scheduler: serialises WRITE / FILL / SCROLL_UP commands from the
// VT100 action units into a cycle-by-cycle single-port text RAM access stream.
module text_ram_scheduler #(
   parameter int unsigned COLUMNS = 80,
   parameter int unsigned ROWS    = 24,
   parameter int unsigned AW      = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [AW-1:0] req_start,
   input  logic [AW-1:0] req_end,
   input  logic [4:0]    req_lines,
   input  logic [15:0]   req_data,
   output logic          done,
   output logic          busy,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic          ram_re,
   output logic [15:0]   ram_wdata,
   input  logic [15:0]   ram_rdata
);

   localparam int unsigned   N      = COLUMNS * ROWS;
   localparam logic [AW-1:0] N_A    = AW'(N);
   localparam logic [AW-1:0] LAST_A = AW'(N - 1);

   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_FILL   = 2'd2;
   localparam logic [1:0] OP_SCROLL = 2'd3;

   typedef enum logic [2:0] {
      IDLE, WRITE, FILL, SC_RD, SC_WR, SC_CLR, FIN
   } state_t;

   state_t        state;
   logic [AW-1:0] dst;       // copy destination counter
   logic [AW-1:0] last;      // final address of the current phase
   logic [AW-1:0] s_off;     // scroll distance in cells
   logic [15:0]   wdata_q;   // fill / blank cell value

   logic [4:0]    lines_eff;
   logic [AW-1:0] fill_end;
   logic [AW-1:0] shift;
   logic          big_scroll;
   logic [AW-1:0] addr_nx;
   logic [AW-1:0] dst_nx;

   // Command decode helpers: clamped fill end, scroll distance, counter increments.
   always_comb begin
      lines_eff  = (req_lines == 5'd0) ? 5'd1 : req_lines;
      fill_end   = (req_end > LAST_A) ? LAST_A : req_end;
      shift      = AW'(32'(lines_eff) * COLUMNS);
      big_scroll = (32'(lines_eff) >= ROWS);
      addr_nx    = ram_addr + AW'(1);
      dst_nx     = dst + AW'(1);
   end

   // Copy writes forward the read data straight from the RAM; otherwise the held cell value.
   assign ram_wdata = (state == SC_WR) ? ram_rdata : wdata_q;

   // Command sequencer with registered RAM strobes, address and status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dst       <= '0;
         last      <= '0;
         s_off     <= '0;
         wdata_q   <= '0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               ram_we <= 1'b0;
               ram_re <= 1'b0;
               if (req_valid) begin
                  wdata_q   <= req_data;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  case (req_op)
                     OP_WRITE: begin
                        if (req_start > LAST_A) begin
                           state <= FIN;
                           done  <= 1'b1;
                        end else begin
                           state    <= WRITE;
                           ram_we   <= 1'b1;
                           ram_addr <= req_start;
                           done     <= 1'b1;
                        end
                     end
                     OP_FILL: begin
                        if (req_start > fill_end) begin
                           state <= FIN;
                           done  <= 1'b1;
                        end else begin
                           state    <= FILL;
                           ram_we   <= 1'b1;
                           ram_addr <= req_start;
                           last     <= fill_end;
                           done     <= (req_start == fill_end);
                        end
                     end
                     OP_SCROLL: begin
                        if (big_scroll) begin
                           state    <= SC_CLR;
                           ram_we   <= 1'b1;
                           ram_addr <= '0;
                           last     <= LAST_A;
                           done     <= (N == 1);
                        end else begin
                           state    <= SC_RD;
                           ram_re   <= 1'b1;
                           ram_addr <= shift;
                           dst      <= '0;
                           s_off    <= shift;
                           last     <= LAST_A - shift;
                        end
                     end
                     default: begin
                        state <= FIN;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            WRITE, FIN: begin
               state     <= IDLE;
               ram_we    <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            FILL, SC_CLR: begin
               if (ram_addr == last) begin
                  state     <= IDLE;
                  ram_we    <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  ram_addr <= addr_nx;
                  done     <= (addr_nx == last);
               end
            end
            SC_RD: begin
               state    <= SC_WR;
               ram_re   <= 1'b0;
               ram_we   <= 1'b1;
               ram_addr <= dst;
            end
            SC_WR: begin
               if (dst == last) begin
                  state    <= SC_CLR;
                  ram_addr <= N_A - s_off;
                  last     <= LAST_A;
                  done     <= ((N_A - s_off) == LAST_A);
               end else begin
                  state    <= SC_RD;
                  ram_we   <= 1'b0;
                  ram_re   <= 1'b1;
                  dst      <= dst_nx;
                  ram_addr <= dst_nx + s_off;
               end
            end
            default: begin
               state     <= IDLE;
               ram_we    <= 1'b0;
               ram_re    <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_ram_scheduler.sv
// Directed bench for text_ram_scheduler with a synchronous single-port RAM model.
module tb_text_ram_scheduler;

   localparam int unsigned AW = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [AW-1:0] req_start;
   logic [AW-1:0] req_end;
   logic [4:0]    req_lines;
   logic [15:0]   req_data;
   logic          done;
   logic          busy;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic          ram_re;
   logic [15:0]   ram_wdata;
   logic [15:0]   ram_rdata;

   logic [15:0]   mem [0:2047];

   int tests  = 0;
   int errors = 0;

   // per-command activity, accumulated by the monitor
   int wr_cnt, rd_cnt, done_cnt, busy_cnt, asc_bad, first_wr, last_wr, done_addr, done_we;
   int both_cnt = 0;
   int idle_acc = 0;
   int lat;
   logic rdy_done, rdy_after;

   text_ram_scheduler #(.COLUMNS(80), .ROWS(24), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_start(req_start), .req_end(req_end), .req_lines(req_lines),
      .req_data(req_data), .done(done), .busy(busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: write and registered read on the rising edge
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   // Activity monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (ram_we) begin
         if (wr_cnt == 0) first_wr = int'(ram_addr);
         else if (int'(ram_addr) != last_wr + 1) asc_bad++;
         last_wr = int'(ram_addr);
         wr_cnt++;
      end
      if (ram_re) rd_cnt++;
      if (ram_we && ram_re) both_cnt++;
      if (req_ready && (ram_we || ram_re)) idle_acc++;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_addr = int'(ram_addr);
         done_we   = int'(ram_we);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic clear_mon();
      wr_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; asc_bad = 0;
      first_wr = -1; last_wr = -1; done_addr = -1; done_we = 0;
   endtask

   // Issue one command, wait (bounded) for done, then sample req_ready one cycle later.
   task automatic do_cmd(input logic [1:0] op, input int s, input int e, input int l,
                         input logic [15:0] d, input bit hold);
      @(negedge clk); #1;
      clear_mon();
      req_op    = op;
      req_start = AW'(s);
      req_end   = AW'(e);
      req_lines = 5'(l);
      req_data  = d;
      req_valid = 1'b1;
      @(negedge clk); #1;
      if (!hold) req_valid = 1'b0;
      lat = 1;
      while (done_cnt == 0 && lat < 5000) begin
         @(negedge clk); #1;
         lat++;
      end
      rdy_done = req_ready;
      @(negedge clk); #1;
      rdy_after = req_ready;
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_op = '0; req_start = '0; req_end = '0;
      req_lines = '0; req_data = '0;
      clear_mon();
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready_in_reset", 32'(req_ready), 1);
      check("rst_we", 32'(ram_we), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b1;
      @(negedge clk); #1;
      check("rst_ready", 32'(req_ready), 1);
      check("rst_done", 32'(done), 0);
      check("rst_addr", 32'(ram_addr), 0);
      check("rst_wdata", 32'(ram_wdata), 0);

      // single write
      do_cmd(2'd1, 85, 0, 0, 16'h0741, 1'b0);
      check("wr_count", 32'(wr_cnt), 1);
      check("wr_addr", 32'(last_wr), 85);
      check("wr_mem", 32'(mem[85]), 32'h0741);
      check("wr_latency", 32'(lat), 1);
      check("wr_done_with_we", 32'(done_we), 1);
      check("wr_done_count", 32'(done_cnt), 1);
      check("wr_ready_at_done", 32'(rdy_done), 0);
      check("wr_ready_after", 32'(rdy_after), 1);

      // write beyond the screen: no RAM access
      do_cmd(2'd1, 1920, 0, 0, 16'h1111, 1'b0);
      check("wr_oob_count", 32'(wr_cnt), 0);
      check("wr_oob_latency", 32'(lat), 1);

      // fill with req_valid held throughout
      do_cmd(2'd2, 160, 239, 0, 16'h0720, 1'b1);
      check("fill_count", 32'(wr_cnt), 80);
      check("fill_first", 32'(first_wr), 160);
      check("fill_last", 32'(last_wr), 239);
      check("fill_ascending", 32'(asc_bad), 0);
      check("fill_done_addr", 32'(done_addr), 239);
      check("fill_done_count", 32'(done_cnt), 1);
      check("fill_busy", 32'(busy_cnt), 80);
      check("fill_mem", 32'(mem[200]), 32'h0720);
      check("fill_ready_after", 32'(rdy_after), 1);

      // empty fill
      do_cmd(2'd2, 100, 50, 0, 16'h2222, 1'b0);
      check("fill_empty_count", 32'(wr_cnt), 0);
      check("fill_empty_latency", 32'(lat), 1);

      // clamped fill
      do_cmd(2'd2, 1900, 2047, 0, 16'h1F23, 1'b0);
      check("clamp_count", 32'(wr_cnt), 20);
      check("clamp_first", 32'(first_wr), 1900);
      check("clamp_last", 32'(last_wr), 1919);
      check("clamp_done_addr", 32'(done_addr), 1919);

      // scroll up one line
      mem[80] <= 16'h0742;
      mem[0]  <= 16'h9999;
      do_cmd(2'd3, 0, 0, 1, 16'h0720, 1'b0);
      check("scr1_cell0", 32'(mem[0]), 32'h0742);
      check("scr1_moved_fill", 32'(mem[1820]), 32'h1F23);
      check("scr1_blank_first", 32'(mem[1840]), 32'h0720);
      check("scr1_blank_last", 32'(mem[1919]), 32'h0720);
      check("scr1_busy", 32'(busy_cnt), 3760);
      check("scr1_reads", 32'(rd_cnt), 1840);
      check("scr1_writes", 32'(wr_cnt), 1920);
      check("scr1_done_addr", 32'(done_addr), 1919);

      // scroll past the screen height: clear only
      do_cmd(2'd3, 0, 0, 30, 16'h0020, 1'b0);
      check("scr30_writes", 32'(wr_cnt), 1920);
      check("scr30_reads", 32'(rd_cnt), 0);
      check("scr30_busy", 32'(busy_cnt), 1920);
      check("scr30_mem", 32'(mem[0]), 32'h0020);

      // zero lines behaves as one
      mem[100] <= 16'h4B4B;
      do_cmd(2'd3, 0, 0, 0, 16'h0720, 1'b0);
      check("scr0_reads", 32'(rd_cnt), 1840);
      check("scr0_busy", 32'(busy_cnt), 3760);
      check("scr0_cell20", 32'(mem[20]), 32'h4B4B);
      check("scr0_done_count", 32'(done_cnt), 1);

      // reset during the tenth write of a full-screen fill
      @(negedge clk); #1;
      clear_mon();
      req_op = 2'd2; req_start = '0; req_end = AW'(1919);
      req_data = 16'h5555; req_valid = 1'b1;
      @(negedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (wr_cnt < 10 && lat < 100) begin
         @(negedge clk); #1;
         lat++;
      end
      check("abort_reached_10th", 32'(wr_cnt), 10);
      #1 rst = 1'b0;
      #1;
      check("abort_we_async", 32'(ram_we), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("abort_ready", 32'(req_ready), 1);
      check("abort_no_more_writes", 32'(wr_cnt), 10);
      check("abort_no_done", 32'(done_cnt), 0);
      check("abort_mem_untouched", 32'(mem[10]), 32'h0020);

      check("never_we_and_re", 32'(both_cnt), 0);
      check("no_access_when_idle", 32'(idle_acc), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/text_ram_scheduler.md
Name: text_ram_scheduler

Overview:
- Sequences all writes into the console text RAM (one 16-bit cell per character: [15:8] attribute, [7:0] char code) on behalf of the VT100 action units.
- Accepts one command at a time: single-cell write, linear fill/erase, or full-screen scroll-up. Expands each command into a cycle-by-cycle RAM read/write stream.
- Sits between the parser's action units (ActionCursor and the erase/print units) and the single-port text RAM that the renderer also reads.

Parameters:
- COLUMNS, 80, characters per row.
- ROWS, 24, rows per screen.
- AW, 11, RAM address width; must satisfy 2^AW >= COLUMNS*ROWS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  command request.
- req_ready  out  1  scheduler can accept a command.
- req_op  in  2  0 = NOP, 1 = WRITE, 2 = FILL, 3 = SCROLL_UP.
- req_start  in  AW  WRITE address, or FILL first address (linear: row*COLUMNS + col).
- req_end  in  AW  FILL last address, inclusive.
- req_lines  in  5  SCROLL_UP line count.
- req_data  in  16  cell value for WRITE, FILL, and the blank cell used by SCROLL_UP.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  command in progress.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data, valid 1 cycle after ram_re.

Behaviour:
- Let N = COLUMNS*ROWS.
- Reset (rst = 0, asynchronous): state IDLE; counters cleared; ram_we, ram_re, done and busy = 0; ram_addr and ram_wdata = 0. Any in-flight command is abandoned with no further RAM accesses. req_ready = 1 immediately after release.
- Handshake:
  - req_ready = (state == IDLE). busy = !req_ready.
  - A command is accepted on a rising edge with req_valid && req_ready; all req_* fields are registered at that edge.
  - req_valid while busy is ignored and not queued.
- States: IDLE, WRITE, FILL, SC_RD, SC_WR, SC_CLR, FIN.
- Accept at edge T:
  - NOP or WRITE with req_start >= N → FIN. done pulses in cycle T+1, no RAM access.
  - WRITE → WRITE. In cycle T+1: ram_we = 1, ram_addr = req_start, ram_wdata = req_data, done = 1. Then IDLE.
  - FILL:
    - e = min(req_end, N-1).
    - If req_start > e → FIN (no writes).
    - Otherwise one write per cycle at addresses req_start..e, ascending, with ram_wdata = req_data. done coincides with the write to e. Then IDLE.
  - SCROLL_UP:
    - n = req_lines, with 0 treated as 1. S = n*COLUMNS.
    - If n >= ROWS → SC_CLR over 0..N-1 with no copy phase.
    - Otherwise, copy loop for dst = 0..N-1-S:
      - SC_RD: ram_re = 1, ram_addr = dst+S.
      - SC_WR: ram_we = 1, ram_addr = dst, ram_wdata = ram_rdata.
      - 2 cycles per cell.
    - Then SC_CLR writes req_data to N-S..N-1, one per cycle. done coincides with the last write.
    - Total busy cycles: 2*(N-S) + S.
- FIN: one cycle, done = 1, then IDLE.
- ram_we and ram_re are never asserted together. Neither is asserted in IDLE.
- Address arithmetic: the counter is AW bits wide. dst+S never exceeds N-1, so no wrap occurs. The comparison against e is an unsigned compare.
- done is high for exactly one cycle per accepted command. req_ready rises in the cycle after done.

Test Plan:
- Reset, then WRITE start = 85, data = 0x0741 → exactly one ram_we at addr 85 with wdata 0x0741; done in the same cycle; req_ready back 1 cycle later.
- FILL 160..239, data 0x0720, with req_valid held high throughout → 80 consecutive writes at addr 160..239; done on addr 239; the extra requests are not accepted until req_ready = 1.
- FILL 100..50 → zero writes, done at T+1. FILL 1900..2047 → 20 writes at 1900..1919 (clamped).
- Preload RAM model with cell[80] = 0x0742, then SCROLL_UP 1, blank 0x0720 → cell[0] = 0x0742; cells 1840..1919 = 0x0720; busy for 3760 cycles.
- SCROLL_UP 30 and SCROLL_UP 0 → 30: 1920 blank writes, no ram_re. 0: behaves as 1 line.
- Assert rst during the 10th write of FILL 0..1919 → ram_we drops asynchronously; no done; after release req_ready = 1 and no further writes occur.
